// File: rtl/id_ex_pipeline_register.sv
// rtl/id_ex_pipeline_register.sv - ID/EX pipeline register with hold, bubble and flush
// A squashed stage clears every control bit so it can never write, access memory or redirect the PC.
module id_ex_pipeline_register #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  bubble,
  input  logic                  flush,
  input  logic                  id_reg_write_enable,
  input  logic                  id_mem_enable,
  input  logic                  id_mem_rw,
  input  logic                  id_mem_to_reg_select,
  input  logic                  id_alu_source_select,
  input  logic                  id_status_bit,
  input  logic                  id_pc_source_select,
  input  logic                  id_mem_size,
  input  logic [3:0]            id_alu_operation,
  input  logic [1:0]            id_addressing_mode,
  input  logic [3:0]            id_condition_code,
  input  logic [DATA_WIDTH-1:0] id_rn_data,
  input  logic [DATA_WIDTH-1:0] id_rm_data,
  input  logic [DATA_WIDTH-1:0] id_rd_data,
  input  logic [DATA_WIDTH-1:0] id_pc_plus4,
  input  logic [11:0]           id_shifter_operand,
  input  logic [23:0]           id_branch_offset,
  input  logic [3:0]            id_rd,
  output logic                  ex_reg_write_enable,
  output logic                  ex_mem_enable,
  output logic                  ex_mem_rw,
  output logic                  ex_mem_to_reg_select,
  output logic                  ex_alu_source_select,
  output logic                  ex_status_bit,
  output logic                  ex_pc_source_select,
  output logic                  ex_mem_size,
  output logic [3:0]            ex_alu_operation,
  output logic [1:0]            ex_addressing_mode,
  output logic [3:0]            ex_condition_code,
  output logic [DATA_WIDTH-1:0] ex_rn_data,
  output logic [DATA_WIDTH-1:0] ex_rm_data,
  output logic [DATA_WIDTH-1:0] ex_rd_data,
  output logic [DATA_WIDTH-1:0] ex_pc_plus4,
  output logic [11:0]           ex_shifter_operand,
  output logic [23:0]           ex_branch_offset,
  output logic [3:0]            ex_rd,
  output logic                  ex_valid,
  output logic [CNT_WIDTH-1:0]  event_count
);

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic squash;
  logic load;
  logic id_has_ctrl;

  // flush beats hold; bubble only acts when the stage is not frozen
  assign squash = flush | (~hold & bubble);
  assign load   = ~flush & ~hold & ~bubble;

  assign id_has_ctrl = |{id_reg_write_enable, id_mem_enable, id_mem_rw, id_mem_to_reg_select,
                         id_alu_source_select, id_status_bit, id_pc_source_select, id_mem_size,
                         id_alu_operation, id_addressing_mode};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_reg_write_enable  <= 1'b0;
      ex_mem_enable        <= 1'b0;
      ex_mem_rw            <= 1'b0;
      ex_mem_to_reg_select <= 1'b0;
      ex_alu_source_select <= 1'b0;
      ex_status_bit        <= 1'b0;
      ex_pc_source_select  <= 1'b0;
      ex_mem_size          <= 1'b0;
      ex_alu_operation     <= 4'd0;
      ex_addressing_mode   <= 2'd0;
      ex_condition_code    <= COND_AL;
      ex_rn_data           <= '0;
      ex_rm_data           <= '0;
      ex_rd_data           <= '0;
      ex_pc_plus4          <= '0;
      ex_shifter_operand   <= 12'd0;
      ex_branch_offset     <= 24'd0;
      ex_rd                <= 4'd0;
      ex_valid             <= 1'b0;
      event_count          <= '0;
    end else if (squash) begin
      // data fields are left alone; with no control bits set they have no effect
      ex_reg_write_enable  <= 1'b0;
      ex_mem_enable        <= 1'b0;
      ex_mem_rw            <= 1'b0;
      ex_mem_to_reg_select <= 1'b0;
      ex_alu_source_select <= 1'b0;
      ex_status_bit        <= 1'b0;
      ex_pc_source_select  <= 1'b0;
      ex_mem_size          <= 1'b0;
      ex_alu_operation     <= 4'd0;
      ex_addressing_mode   <= 2'd0;
      ex_valid             <= 1'b0;
      if (event_count != CNT_MAX) begin
        event_count <= event_count + CNT_ONE;
      end
    end else if (load) begin
      ex_reg_write_enable  <= id_reg_write_enable;
      ex_mem_enable        <= id_mem_enable;
      ex_mem_rw            <= id_mem_rw;
      ex_mem_to_reg_select <= id_mem_to_reg_select;
      ex_alu_source_select <= id_alu_source_select;
      ex_status_bit        <= id_status_bit;
      ex_pc_source_select  <= id_pc_source_select;
      ex_mem_size          <= id_mem_size;
      ex_alu_operation     <= id_alu_operation;
      ex_addressing_mode   <= id_addressing_mode;
      ex_condition_code    <= id_condition_code;
      ex_rn_data           <= id_rn_data;
      ex_rm_data           <= id_rm_data;
      ex_rd_data           <= id_rd_data;
      ex_pc_plus4          <= id_pc_plus4;
      ex_shifter_operand   <= id_shifter_operand;
      ex_branch_offset     <= id_branch_offset;
      ex_rd                <= id_rd;
      ex_valid             <= id_has_ctrl;
    end
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Pipeline register between decode (control unit, register file read) and execute (ALU, shifter, condition check).
- Captures the decoded control word, operand values and instruction fields each cycle.
- Supports stall (hold), bubble insertion (load-use), and flush (taken branch).
- Keeps a saturating count of inserted bubbles and flushes for debug.

Parameters:
- DATA_WIDTH, 32, width of operand and PC datapaths
- CNT_WIDTH, 16, width of the bubble/flush event counter

Ports:
- clk  input  1  pipeline clock; rising edge
- reset  input  1  asynchronous, active-high reset
- hold  input  1  freeze the stage; all outputs keep their value
- bubble  input  1  load a NOP control word instead of the decode inputs
- flush  input  1  squash the stage contents (taken branch)
- id_reg_write_enable, id_mem_enable, id_mem_rw, id_mem_to_reg_select, id_alu_source_select, id_status_bit, id_pc_source_select, id_mem_size  input  1 each  decoded control signals
- id_alu_operation  input  4  ALU operation code
- id_addressing_mode  input  2  addressing mode
- id_condition_code  input  4  instruction[31:28]
- id_rn_data, id_rm_data, id_rd_data  input  DATA_WIDTH  register file read data (Rd data is the store source)
- id_pc_plus4  input  DATA_WIDTH  PC+4 of the instruction
- id_shifter_operand  input  12  instruction[11:0]
- id_branch_offset  input  24  instruction[23:0]
- id_rd  input  4  destination register index
- ex_*  output  same as each id_* input  registered copies of every id_* input
- ex_valid  output  1  stage holds a real instruction
- event_count  output  CNT_WIDTH  number of bubbles plus flushes since reset, saturating

Behaviour:
- Reset (asynchronous, immediate): every ex_* output is 0, ex_condition_code is 4'b1110 (AL), ex_valid is 0, event_count is 0.
- Only one action runs per rising edge. Priority is flush > hold > bubble > load.
- flush=1:
  - All ex_* control signals (reg_write_enable, mem_enable, mem_rw, mem_to_reg_select, alu_source_select, status_bit, pc_source_select, mem_size) become 0.
  - ex_alu_operation becomes 0 and ex_addressing_mode becomes 0.
  - ex_valid becomes 0.
  - Data fields (rn/rm/rd data, pc_plus4, shifter_operand, branch_offset, rd, condition_code) keep their previous value.
  - event_count increments.
  - flush overrides hold.
- hold=1 and flush=0: every register keeps its value and event_count does not change. bubble is ignored while hold is set.
- bubble=1 (hold=0, flush=0): same effect as flush, including event_count incrementing.
- Load (all three inputs 0):
  - Every ex_* output takes its id_* value on the edge.
  - ex_valid becomes 1, unless every id_* control bit, id_alu_operation and id_addressing_mode are all 0. In that case ex_valid becomes 0 (decoded NOP).
- Latency: exactly 1 cycle from id_* to ex_*. No combinational path from inputs to outputs.
- event_count saturates at all ones and never wraps.
- Asserting reset mid-stream clears everything asynchronously. The first edge after reset deasserts performs a normal action according to the priority above.
- A squashed stage (bubble or flush) must never cause a register write, memory access, flag update or PC redirect, whatever its data fields contain.

Test Plan:
- Reset: assert reset for 2 cycles with random id_* inputs -> all ex_* are 0, ex_condition_code=4'hE, ex_valid=0, event_count=0; deassert reset, load an ADD (id_reg_write_enable=1, id_alu_operation=4'b0000, id_rn_data=32'h5) -> next cycle ex_reg_write_enable=1, ex_rn_data=32'h5, ex_valid=1.
- Hold: load an LDR (id_mem_enable=1, id_mem_to_reg_select=1, id_rd=4'd3), then hold=1 for 3 cycles while the inputs change to an STR -> ex_* still show the LDR, ex_rd=3, event_count unchanged.
- Bubble: LDR in the stage, then bubble=1 for one cycle with an SUB (id_reg_write_enable=1, id_alu_operation=4'b0010) on the inputs -> all ex control bits 0, ex_valid=0, event_count=1; next cycle with bubble=0 the SUB loads.
- Flush vs hold: assert flush=1 and hold=1 together with a valid STR in the stage -> ex_mem_enable=0, ex_mem_rw=0, ex_valid=0, event_count increments; the data fields keep the STR values.
- Saturation: CNT_WIDTH=4, apply 20 consecutive bubbles -> event_count stops at 4'hF and does not wrap.
- Decoded NOP: load with all id_* control bits 0 and id_alu_operation=0 -> ex_valid=0 and event_count unchanged.
